// File: rtl/ac_con_pkg.sv
// Shared definitions for the AC controller zero-crossing front end:
// counter width, FSM state encoding and the default line-loss timeout.
package ac_con_pkg;

    localparam int ZC_CNT_W   = 21;
    localparam int ZC_TIMEOUT = 200000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_POS   = 2'd1,
        S_NEG   = 2'd2,
        S_FAULT = 2'd3
    } zc_state_t;

    // Half-cycle state that corresponds to an accepted line level.
    function automatic zc_state_t level_state(input logic lvl);
        return lvl ? S_POS : S_NEG;
    endfunction

endpackage

// File: rtl/zc_sync_deb.sv
// Synchroniser and debouncer for the raw mains comparator input. Produces the
// accepted line level and a one-cycle strobe whenever a new level is accepted.
module zc_sync_deb #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic change
);

    localparam logic [4:0] DEB_W = 5'(DEB_CYCLES);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] fill_reg;
    logic                   s;
    logic                   s_valid;

    logic [3:0] deb_cnt_reg, deb_cnt_next;
    logic       level_reg, level_next;
    logic       known_reg, known_next;
    logic       change_reg, change_next;
    logic [4:0] run;

    // fill_reg marks when the chain holds real samples rather than reset values,
    // so a level sitting on DAC across reset is not mistaken for a crossing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
            fill_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], din};
            fill_reg <= {fill_reg[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s       = sync_reg[SYNC_STAGES-1];
    assign s_valid = fill_reg[SYNC_STAGES-1];

    always_comb begin
        deb_cnt_next = deb_cnt_reg;
        level_next   = level_reg;
        known_next   = known_reg;
        change_next  = 1'b0;
        run          = {1'b0, deb_cnt_reg} + 5'd1;
        if (s_valid) begin
            if (!known_reg) begin
                // Level unknown: track the run length of identical samples.
                if (deb_cnt_reg == 4'd0 || s != level_reg) begin
                    run = 5'd1;
                end
                level_next = s;
                if (run >= DEB_W) begin
                    known_next   = 1'b1;
                    deb_cnt_next = '0;
                    change_next  = 1'b1;
                end else begin
                    deb_cnt_next = run[3:0];
                end
            end else if (s != level_reg) begin
                if (run >= DEB_W) begin
                    level_next   = s;
                    deb_cnt_next = '0;
                    change_next  = 1'b1;
                end else begin
                    deb_cnt_next = run[3:0];
                end
            end else begin
                deb_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_reg <= '0;
            level_reg   <= 1'b0;
            known_reg   <= 1'b0;
            change_reg  <= 1'b0;
        end else begin
            deb_cnt_reg <= deb_cnt_next;
            level_reg   <= level_next;
            known_reg   <= known_next;
            change_reg  <= change_next;
        end
    end

    assign level  = level_reg;
    assign change = change_reg;

endmodule

// File: rtl/zc_conditioner.sv
// Mains zero-crossing conditioner: debounced crossing strobe with polarity,
// half-period measurement and line-loss detection.
module zc_conditioner
    import ac_con_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1,
    parameter int CNT_W       = ZC_CNT_W,
    parameter int MIN_HALF    = 2,
    parameter int TIMEOUT     = ZC_TIMEOUT
) (
    input  logic             SYS_CLK,
    input  logic             A_RESET,
    input  logic             DAC,
    output logic             ZC,
    output logic             POL,
    output logic [CNT_W-1:0] HALF_PERIOD,
    output logic             PERIOD_VALID,
    output logic             LINE_FAULT
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic acc_level;
    logic acc_change;

    zc_state_t        state_reg, state_next;
    logic [CNT_W-1:0] half_cnt_reg, half_cnt_next;
    logic             primed_reg, primed_next;
    logic             zc_reg, zc_next;
    logic             pol_reg, pol_next;
    logic [CNT_W-1:0] half_period_reg, half_period_next;
    logic             period_valid_reg, period_valid_next;
    logic             line_fault_reg, line_fault_next;

    zc_sync_deb #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sync_deb (
        .clk   (SYS_CLK),
        .rst   (A_RESET),
        .din   (DAC),
        .level (acc_level),
        .change(acc_change)
    );

    always_ff @(posedge SYS_CLK or posedge A_RESET) begin
        if (A_RESET) begin
            state_reg        <= S_IDLE;
            half_cnt_reg     <= '0;
            primed_reg       <= 1'b0;
            zc_reg           <= 1'b0;
            pol_reg          <= 1'b0;
            half_period_reg  <= '0;
            period_valid_reg <= 1'b0;
            line_fault_reg   <= 1'b0;
        end else begin
            state_reg        <= state_next;
            half_cnt_reg     <= half_cnt_next;
            primed_reg       <= primed_next;
            zc_reg           <= zc_next;
            pol_reg          <= pol_next;
            half_period_reg  <= half_period_next;
            period_valid_reg <= period_valid_next;
            line_fault_reg   <= line_fault_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        half_cnt_next     = half_cnt_reg;
        primed_next       = primed_reg;
        zc_next           = 1'b0;
        pol_next          = pol_reg;
        half_period_next  = half_period_reg;
        period_valid_next = period_valid_reg;
        line_fault_next   = line_fault_reg;

        // half_cnt holds the distance to the last crossing, saturating at TIMEOUT.
        if (state_reg != S_IDLE && half_cnt_reg != TIMEOUT_C) begin
            half_cnt_next = half_cnt_reg + ONE_C;
        end

        case (state_reg)
            S_IDLE: begin
                if (acc_change) begin
                    state_next    = level_state(acc_level);
                    pol_next      = acc_level;
                    half_cnt_next = ONE_C;
                end
            end
            S_POS, S_NEG: begin
                if (acc_change) begin
                    state_next    = level_state(acc_level);
                    zc_next       = 1'b1;
                    pol_next      = acc_level;
                    half_cnt_next = ONE_C;
                    if (!primed_reg) begin
                        primed_next = 1'b1;
                    end else if (half_cnt_reg >= MIN_C) begin
                        half_period_next  = half_cnt_reg;
                        period_valid_next = 1'b1;
                    end else begin
                        period_valid_next = 1'b0;
                    end
                end else if (half_cnt_reg == TIMEOUT_C) begin
                    state_next        = S_FAULT;
                    line_fault_next   = 1'b1;
                    period_valid_next = 1'b0;
                    primed_next       = 1'b0;
                end
            end
            S_FAULT: begin
                // Recovery crossing is not measured but arms the next one.
                if (acc_change) begin
                    state_next      = level_state(acc_level);
                    zc_next         = 1'b1;
                    pol_next        = acc_level;
                    half_cnt_next   = ONE_C;
                    line_fault_next = 1'b0;
                    primed_next     = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ZC           = zc_reg;
    assign POL          = pol_reg;
    assign HALF_PERIOD  = half_period_reg;
    assign PERIOD_VALID = period_valid_reg;
    assign LINE_FAULT   = line_fault_reg;

endmodule

// File: tb/tb_zc_conditioner.sv
// Bench for zc_conditioner: two instances (fast debounce / slow debounce) checked
// against an event-level reference model through a scoreboard queue.
`timescale 1ns/1ps
module tb_zc_conditioner;

    localparam int CW   = 21;
    localparam int SYNC = 2;
    localparam int MAXC = 12000;

    typedef struct {
        int inst;
        int edge_n;
        bit kind;   // 0 = crossing strobe, 1 = fault onset
        bit pol;
        int hp;
        bit pv;
        bit lf;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    dac;
    logic [1:0]    zc, pol, pv, lf;
    logic [CW-1:0] hp_a, hp_b;

    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    ev_t q[$];

    // reference model state, one slot per instance
    bit  hist [2][MAXC];
    int  rel_edge;
    bit  known [2], deb_lvl [2], pend [2], pend_lvl [2];
    bit  idle [2], faulted [2], primed [2];
    int  anchor [2];
    bit  m_pol [2], m_pv [2], m_lf [2];
    int  m_hp [2];
    logic [1:0] lf_prev;

    always #50 clk = ~clk;

    zc_conditioner #(
        .SYNC_STAGES(SYNC), .DEB_CYCLES(1), .CNT_W(CW), .MIN_HALF(2), .TIMEOUT(50)
    ) u_a (
        .SYS_CLK(clk), .A_RESET(rst), .DAC(dac[0]), .ZC(zc[0]), .POL(pol[0]),
        .HALF_PERIOD(hp_a), .PERIOD_VALID(pv[0]), .LINE_FAULT(lf[0])
    );

    zc_conditioner #(
        .SYNC_STAGES(SYNC), .DEB_CYCLES(3), .CNT_W(CW), .MIN_HALF(4), .TIMEOUT(60)
    ) u_b (
        .SYS_CLK(clk), .A_RESET(rst), .DAC(dac[1]), .ZC(zc[1]), .POL(pol[1]),
        .HALF_PERIOD(hp_b), .PERIOD_VALID(pv[1]), .LINE_FAULT(lf[1])
    );

    function automatic int p_deb(input int i);  return (i == 0) ? 1 : 3;   endfunction
    function automatic int p_min(input int i);  return (i == 0) ? 2 : 4;   endfunction
    function automatic int p_to(input int i);   return (i == 0) ? 50 : 60; endfunction
    function automatic int get_hp(input int i); return (i == 0) ? int'(hp_a) : int'(hp_b); endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            known[i] = 0; deb_lvl[i] = 0; pend[i] = 0; pend_lvl[i] = 0;
            idle[i] = 1; faulted[i] = 0; primed[i] = 0; anchor[i] = 0;
            m_pol[i] = 0; m_pv[i] = 0; m_lf[i] = 0; m_hp[i] = 0;
        end
        q.delete();
    endtask

    task automatic push_ev(input int i, input int n, input bit kind);
        ev_t e;
        e.inst = i; e.edge_n = n; e.kind = kind;
        e.pol = m_pol[i]; e.hp = m_hp[i]; e.pv = m_pv[i]; e.lf = m_lf[i];
        q.push_back(e);
    endtask

    // One clock edge of the model: act on a crossing accepted at the previous
    // edge, then decide acceptance from the window of synchronised samples.
    task automatic model_edge(input int i, input int n);
        int  k, d;
        bit  all_eq, all_ne;
        hist[i][n] = dac[i];
        if (pend[i]) begin
            if (idle[i]) begin
                idle[i] = 0; m_pol[i] = pend_lvl[i]; anchor[i] = n;
            end else begin
                d = n - anchor[i];
                if (faulted[i]) begin
                    faulted[i] = 0; m_lf[i] = 0; primed[i] = 1;
                end else if (primed[i]) begin
                    if (d >= p_min(i)) begin m_hp[i] = d; m_pv[i] = 1; end
                    else m_pv[i] = 0;
                end else begin
                    primed[i] = 1;
                end
                m_pol[i] = pend_lvl[i]; anchor[i] = n;
                push_ev(i, n, 1'b0);
            end
        end else if (!idle[i] && !faulted[i] && (n - anchor[i]) == p_to(i)) begin
            faulted[i] = 1; m_lf[i] = 1; m_pv[i] = 0; primed[i] = 0;
            push_ev(i, n, 1'b1);
        end
        pend[i] = 0;
        k = n - SYNC;
        if (k - p_deb(i) + 1 >= rel_edge) begin
            all_eq = 1; all_ne = 1;
            for (int j = 0; j < p_deb(i); j++) begin
                if (hist[i][k-j] != hist[i][k]) all_eq = 0;
                if (hist[i][k-j] == deb_lvl[i]) all_ne = 0;
            end
            if (!known[i] && all_eq) begin
                known[i] = 1; deb_lvl[i] = hist[i][k]; pend[i] = 1; pend_lvl[i] = hist[i][k];
            end else if (known[i] && all_ne) begin
                deb_lvl[i] = ~deb_lvl[i]; pend[i] = 1; pend_lvl[i] = deb_lvl[i];
            end
        end
    endtask

    initial begin
        model_reset();
        rel_edge = 1;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
                $fatal(1, "cycle budget exceeded");
            end
            if (rst) begin
                rel_edge = cyc + 1;
                model_reset();
            end else begin
                for (int i = 0; i < 2; i++) model_edge(i, cyc);
            end
        end
    end

    task automatic check_event(input int i);
        int  idx;
        bit  gk;
        ev_t e;
        idx = -1;
        gk  = zc[i] ? 1'b0 : 1'b1;
        foreach (q[k]) if (idx < 0 && q[k].inst == i) idx = k;
        total++;
        if (idx < 0) begin
            bad++;
            $display("FAIL unexpected_event inst=%0d cyc=%0d got kind=%0d required none", i, cyc, gk);
        end else begin
            e = q[idx];
            q.delete(idx);
            if (e.edge_n != cyc || e.kind != gk || e.pol != pol[i] || e.hp != get_hp(i)
                || e.pv != pv[i] || e.lf != lf[i]) begin
                bad++;
                $display("FAIL event inst=%0d got(cyc=%0d kind=%0d pol=%0b hp=%0d pv=%0b lf=%0b) required(cyc=%0d kind=%0d pol=%0b hp=%0d pv=%0b lf=%0b)",
                         i, cyc, gk, pol[i], get_hp(i), pv[i], lf[i],
                         e.edge_n, e.kind, e.pol, e.hp, e.pv, e.lf);
            end else begin
                $display("event inst=%0d cyc=%0d %s pol=%0b hp=%0d pv=%0b lf=%0b",
                         i, cyc, gk ? "fault" : "zc", pol[i], get_hp(i), pv[i], lf[i]);
            end
        end
    endtask

    task automatic flush_missed(input int i);
        for (int k = q.size() - 1; k >= 0; k--) begin
            if (q[k].inst == i && q[k].edge_n <= cyc) begin
                total++; bad++;
                $display("FAIL missed_event inst=%0d cyc=%0d got none required kind=%0d at cyc=%0d",
                         i, cyc, q[k].kind, q[k].edge_n);
                q.delete(k);
            end
        end
    endtask

    initial begin
        lf_prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                lf_prev = '0;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (zc[i] || (lf[i] && !lf_prev[i])) check_event(i);
                    flush_missed(i);
                    lf_prev[i] = lf[i];
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            total++;
            if (zc[i] !== 1'b0 || pol[i] !== 1'b0 || get_hp(i) != 0 || pv[i] !== 1'b0 || lf[i] !== 1'b0) begin
                bad++;
                $display("FAIL %s inst=%0d got zc=%b pol=%b hp=%0d pv=%b lf=%b required all 0",
                         tag, i, zc[i], pol[i], get_hp(i), pv[i], lf[i]);
            end else begin
                $display("%s inst=%0d outputs 0", tag, i);
            end
        end
    endtask

    task automatic check_val(input string tag, input int got, input int req);
        total++;
        if (got != req) begin
            bad++;
            $display("FAIL %s got=%0d required=%0d", tag, got, req);
        end else begin
            $display("%s = %0d", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tog(input int i);
        @(negedge clk);
        dac[i] = ~dac[i];
    endtask

    int hold [2];

    initial begin
        dac = 2'b00;
        rst = 1'b1;
        step(3);
        check_zero("reset_state");
        dac[1] = 1'b1;
        #5 rst = 1'b0;

        // fast toggling: crossings every 2 cycles
        repeat (12) begin
            step(1);
            tog(0);
        end
        check_val("toggle_hp", int'(hp_a), 2);
        check_val("toggle_pv", int'(pv[0]), 1);

        // stuck input, then recovery and re-measurement
        step(60);
        check_val("stuck_lf", int'(lf[0]), 1);
        check_val("stuck_pv", int'(pv[0]), 0);
        tog(0); step(9);
        tog(0); step(9);
        tog(0); step(8);
        check_val("recover_hp", int'(hp_a), 10);
        check_val("recover_lf", int'(lf[0]), 0);

        // slow debounce: glitches rejected, short half rejected
        dac[1] = 1'b0; step(1);
        dac[1] = 1'b1; step(4);
        dac[1] = 1'b0; step(2);
        dac[1] = 1'b1; step(5);
        tog(1); step(9);
        tog(1); step(9);
        tog(1); step(2);
        tog(1); step(10);
        check_val("short_half_hp", int'(hp_b), 10);
        check_val("short_half_pv", int'(pv[1]), 0);

        // acceptance on the timeout edge
        tog(0); step(4);
        tog(0); step(49);
        tog(0); step(6);
        check_val("tie_hp", int'(hp_a), 50);
        check_val("tie_lf", int'(lf[0]), 0);

        // asynchronous reset in the middle of a half-cycle
        tog(0); step(3);
        #10 rst = 1'b1;
        #1 check_zero("async_reset");
        step(2);
        #5 rst = 1'b0;
        step(12);

        // randomized crossings with occasional glitches
        hold[0] = 3; hold[1] = 5;
        repeat (3000) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (hold[i] == 0) begin
                    dac[i] = ~dac[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : $urandom_range(1, 64);
                end else begin
                    hold[i]--;
                end
            end
        end
        step(10);
        check_val("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
